// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates an instruction-fetch port and a data load/store
// port onto a single byte-wide RAM/IO bus.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   rdy            global enable, low freezes all state and blocks writes
//   if_req/if_addr/if_flush -> if_done/if_data   fetch port (DATA_W/8 bytes)
//   d_req/d_we/d_size/d_signed/d_addr/d_wdata -> d_done/d_rdata   data port
//   mem_din        read byte for the address driven in the previous cycle
//   mem_dout/mem_a/mem_wr   byte bus towards RAM/IO
//   io_buffer_full IO write FIFO full, stalls writes into IO space only
//   dbg_state      current FSM state (IDLE=0, READ=1, WRITE=2, FIN=3)
//
// Handshake: a requester raises req (with its fields stable) and holds it
// until the matching one-cycle done pulse, then drops req at the next edge.
// The FIN state sits between done and the next grant, so a req still high
// in the done cycle is never granted a second time. A fetch may also be
// withdrawn with if_flush, which never produces a done pulse.
module mem_arb_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  output logic [1:0]        dbg_state
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, FIN = 2'd3} state_t;

  state_t            state;
  logic [3:0]        idx;       // bytes issued (READ) / byte being written (WRITE)
  logic [3:0]        nbytes;
  logic              is_fetch;
  logic              is_write;
  logic              sgn;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr_q;    // last address issued while rdy was high
  logic [DATA_W-1:0] buf_q;     // byte lanes collected during READ
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic              grant_d, grant_f, flushing;
  logic [3:0]        n_d;
  logic [ADDR_W-1:0] cur_addr;
  logic              issue_rd, issue_wr, wr_ok;
  logic [7:0]        wbyte;
  logic              top_bit;
  logic [DATA_W-1:0] ext;

  assign grant_d  = (state == IDLE) && d_req;
  assign grant_f  = (state == IDLE) && !d_req && if_req && !if_flush;
  assign n_d      = 4'd1 << d_size;
  assign flushing = (state == READ) && is_fetch && if_flush;

  always_comb begin
    cur_addr = base + ADDR_W'(idx);
    if (state == IDLE) cur_addr = grant_d ? d_addr : if_addr;
    // A flushed fetch issues nothing, so no IO byte is read speculatively.
    issue_rd = grant_f || (grant_d && !d_we) ||
               ((state == READ) && (idx < nbytes) && !flushing);
    issue_wr = (grant_d && d_we) || (state == WRITE);
    wr_ok    = issue_wr && !(io_buffer_full && (cur_addr >= IO_BASE));
    // idx is 0 in IDLE, so the grant cycle drives byte 0.
    wbyte = 8'h00;
    for (int i = 0; i < NB; i++)
      if (idx == 4'(i)) wbyte = d_wdata[i*8 +: 8];
  end

  // Load extension: lanes at or above nbytes take the fill bit.
  always_comb begin
    top_bit = 1'b0;
    for (int i = 0; i < NB; i++)
      if (nbytes == 4'(i + 1)) top_bit = buf_q[i*8 + 7];
    ext = '0;
    for (int i = 0; i < NB; i++)
      ext[i*8 +: 8] = (4'(i) < nbytes) ? buf_q[i*8 +: 8] : {8{sgn & top_bit}};
  end

  // While rdy is low mem_a replays the last issued address so mem_din keeps
  // presenting the byte still waiting to be captured.
  assign mem_a     = rst ? '0 : (rdy && (issue_rd || issue_wr)) ? cur_addr : addr_q;
  assign mem_wr    = !rst && rdy && wr_ok;
  assign mem_dout  = (rst || !issue_wr) ? 8'h00 : wbyte;
  assign if_done   = !rst && rdy && (state == FIN) && is_fetch && !if_flush;
  assign d_done    = !rst && rdy && (state == FIN) && !is_fetch;
  assign if_data   = if_done ? buf_q : if_data_q;
  assign d_rdata   = (d_done && !is_write) ? ext : d_rdata_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      nbytes    <= '0;
      is_fetch  <= 1'b0;
      is_write  <= 1'b0;
      sgn       <= 1'b0;
      base      <= '0;
      addr_q    <= '0;
      buf_q     <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else if (rdy) begin
      if (issue_rd || issue_wr) addr_q <= cur_addr;
      case (state)
        IDLE: begin
          if (grant_d || grant_f) begin
            base     <= cur_addr;
            is_fetch <= grant_f;
            is_write <= grant_d && d_we;
            sgn      <= d_signed;
            nbytes   <= grant_d ? n_d : 4'(NB);
            if (grant_d && d_we) begin
              if (wr_ok) begin
                idx   <= 4'd1;
                state <= (n_d == 4'd1) ? FIN : WRITE;
              end else begin
                state <= WRITE;
              end
            end else begin
              idx   <= 4'd1;
              state <= READ;
            end
          end
        end
        READ: begin
          if (flushing) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            // Byte issued one cycle ago (lane idx-1) is on mem_din now.
            for (int i = 0; i < NB; i++)
              if (idx == 4'(i + 1)) buf_q[i*8 +: 8] <= mem_din;
            if (idx == nbytes) state <= FIN;
            else               idx   <= idx + 4'd1;
          end
        end
        WRITE: begin
          if (wr_ok) begin
            if (idx == nbytes - 4'd1) state <= FIN;
            idx <= idx + 4'd1;
          end
        end
        FIN: begin
          state <= IDLE;
          idx   <= '0;
          if (if_done) if_data_q <= buf_q;
          if (d_done && !is_write) d_rdata_q <= ext;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
module tb_mem_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        d_req, d_we, d_signed, d_done;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram [0:1023];
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];

  mem_arb_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // bus model: one-cycle read latency, write log for the scoreboard
  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
      got_q.push_back({mem_a, mem_dout});
    end
  end

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_signed = 1'b0;
    d_addr = '0; d_wdata = '0; io_buffer_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
    checks++; if ({mem_wr, mem_dout, if_done, d_done} !== 11'h0) begin failures++; $display("FAIL reset_strobes got=%h exp=0", {mem_wr, mem_dout, if_done, d_done}); end
    checks++; if ({if_data, d_rdata} !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {if_data, d_rdata}); end
    @(posedge clk); #1;
    if_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    @(posedge clk); #1;
    for (int k = 0; k <= 6; k++) begin
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h100; end
      if (k == 6) if_req = 1'b0;
      @(negedge clk);
      if (k <= 3) begin
        checks++; if (mem_a !== 32'h100 + 32'(k)) begin failures++; $display("FAIL fetch_addr k=%0d got=%h exp=%h", k, mem_a, 32'h100 + 32'(k)); end
      end
      checks++; if (if_done !== (k == 5)) begin failures++; $display("FAIL fetch_done k=%0d got=%b", k, if_done); end
      if (k == 5) begin
        checks++; if (if_data !== 32'h0000_0513) begin failures++; $display("FAIL fetch_data got=%h exp=00000513", if_data); end
      end
      if (k == 6) begin
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL fetch_idle got=%0d exp=0", dbg_state); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arbitration();
    @(posedge clk); #1;
    for (int k = 0; k <= 9; k++) begin
      if (k == 0) begin
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_signed = 1'b1; d_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h100;
      end
      if (k == 3) d_req = 1'b0;
      if (k == 9) if_req = 1'b0;
      @(negedge clk);
      if (k == 0) begin
        checks++; if (mem_a !== 32'h200) begin failures++; $display("FAIL arb_load_first got=%h exp=00000200", mem_a); end
      end
      checks++; if (d_done !== (k == 2)) begin failures++; $display("FAIL arb_d_done k=%0d got=%b", k, d_done); end
      if (k == 2) begin
        checks++; if (d_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL signed_byte got=%h exp=ffffff80", d_rdata); end
      end
      if (k == 3) begin
        checks++; if (mem_a !== 32'h100) begin failures++; $display("FAIL arb_fetch_grant got=%h exp=00000100", mem_a); end
      end
      checks++; if (if_done !== (k == 8)) begin failures++; $display("FAIL arb_if_done k=%0d got=%b", k, if_done); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_half_load();
    @(posedge clk); #1;
    for (int k = 0; k <= 4; k++) begin
      if (k == 0) begin
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_signed = 1'b0; d_addr = 32'h210;
      end
      if (k == 4) d_req = 1'b0;
      @(negedge clk);
      checks++; if (d_done !== (k == 3)) begin failures++; $display("FAIL half_done k=%0d got=%b", k, d_done); end
      if (k >= 3) begin
        checks++; if (d_rdata !== 32'h0000_8001) begin failures++; $display("FAIL unsigned_half k=%0d got=%h exp=00008001", k, d_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_io_backpressure();
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({32'h0003_0000, 8'hEF});
    exp_q.push_back({32'h0003_0001, 8'hBE});
    exp_q.push_back({32'h0003_0002, 8'hAD});
    exp_q.push_back({32'h0003_0003, 8'hDE});
    @(posedge clk); #1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) begin
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h0003_0000; d_wdata = 32'hDEAD_BEEF;
      end
      io_buffer_full = (k >= 2 && k <= 4);
      if (k == 8) d_req = 1'b0;
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL io_full_wr k=%0d got=%b exp=0", k, mem_wr); end
      end
      checks++; if (d_done !== (k == 7)) begin failures++; $display("FAIL store_done k=%0d got=%b", k, d_done); end
      @(posedge clk); #1;
    end
    io_buffer_full = 1'b0;
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL store_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL store_byte i=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (d_rdata !== 32'h0000_8001) begin failures++; $display("FAIL rdata_hold got=%h exp=00008001", d_rdata); end
  endtask

  task automatic test_ram_write_ignores_full();
    got_q.delete();
    @(posedge clk); #1;
    for (int k = 0; k <= 2; k++) begin
      if (k == 0) begin
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h300; d_wdata = 32'h0000_005A;
        io_buffer_full = 1'b1;
      end
      if (k == 2) begin d_req = 1'b0; io_buffer_full = 1'b0; end
      @(negedge clk);
      if (k == 0) begin
        checks++; if ({mem_wr, mem_dout} !== 9'h15A) begin failures++; $display("FAIL ram_wr_full got=%h exp=15a", {mem_wr, mem_dout}); end
      end
      checks++; if (d_done !== (k == 1)) begin failures++; $display("FAIL ram_wr_done k=%0d got=%b", k, d_done); end
      @(posedge clk); #1;
    end
    checks++; if (ram[10'h300] !== 8'h5A) begin failures++; $display("FAIL ram_wr_data got=%h exp=5a", ram[10'h300]); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    for (int k = 0; k <= 6; k++) begin
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h100; end
      if (k == 1) begin
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_signed = 1'b0; d_addr = 32'h101;
      end
      if_flush = (k == 2);
      if (k == 3) if_req = 1'b0;
      if (k == 6) d_req = 1'b0;
      @(negedge clk);
      checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL flush_no_done k=%0d got=%b exp=0", k, if_done); end
      if (k == 3) begin
        checks++; if (dbg_state !== 2'd0 || mem_a !== 32'h101) begin failures++; $display("FAIL flush_regrant state=%0d mem_a=%h exp=0/00000101", dbg_state, mem_a); end
      end
      if (k == 5) begin
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h0000_0005) begin failures++; $display("FAIL flush_load done=%b data=%h exp=1/00000005", d_done, d_rdata); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rdy_stall();
    @(posedge clk); #1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h100; end
      rdy = !(k == 2 || k == 3);
      if (k == 8) if_req = 1'b0;
      @(negedge clk);
      if (k == 2 || k == 3) begin
        checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h101) begin failures++; $display("FAIL stall_bus k=%0d wr=%b a=%h exp=0/00000101", k, mem_wr, mem_a); end
      end
      checks++; if (if_done !== (k == 7)) begin failures++; $display("FAIL stall_done k=%0d got=%b", k, if_done); end
      if (k == 7) begin
        checks++; if (if_data !== 32'h0000_0513) begin failures++; $display("FAIL stall_data got=%h exp=00000513", if_data); end
      end
      if (k == 8) begin
        checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL stall_idle got=%0d exp=0", dbg_state); end
      end
      @(posedge clk); #1;
    end
    rdy = 1'b1;
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    for (int k = 0; k <= 6; k++) begin
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h100; end
      rst = (k == 2);
      if (k == 3) if_req = 1'b0;
      @(negedge clk);
      checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL midrst_no_done k=%0d got=%b exp=0", k, if_done); end
      if (k == 2) begin
        checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL midrst_mem_a got=%h exp=0", mem_a); end
      end
      if (k == 4) begin
        checks++; if (dbg_state !== 2'd0 || if_data !== 32'h0) begin failures++; $display("FAIL midrst_idle state=%0d data=%h exp=0/0", dbg_state, if_data); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
    ram[10'h200] = 8'h80;
    ram[10'h210] = 8'h01; ram[10'h211] = 8'h80;
    test_reset();
    test_fetch();
    test_arbitration();
    test_half_load();
    test_io_backpressure();
    test_ram_write_ignores_full();
    test_flush();
    test_rdy_stall();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
